// File: rtl/riscv_base_div_ctrl.sv
// Issue/launch/writeback controller sitting in front of the base divider.
// Optional watchdog on the divider response: define RISCV_DIV_TIMEOUT_EN.
module riscv_base_div_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [31:0] issue_opcode_i,
  input  logic [31:0] issue_pc_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [4:0]  issue_ra_idx_i,
  input  logic [4:0]  issue_rb_idx_i,
  input  logic [31:0] issue_ra_operand_i,
  input  logic [31:0] issue_rb_operand_i,
  output logic        div_valid_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_pc_o,
  output logic [4:0]  div_rd_idx_o,
  output logic [4:0]  div_ra_idx_o,
  output logic [4:0]  div_rb_idx_o,
  output logic [31:0] div_ra_operand_o,
  output logic [31:0] div_rb_operand_o,
  input  logic        div_wb_valid_i,
  input  logic [31:0] div_wb_value_i,
  input  logic        flush_i,
  input  logic [4:0]  hz_ra_idx_i,
  input  logic [4:0]  hz_rb_idx_i,
  output logic        hazard_o,
  output logic        rf_wr_valid_o,
  output logic [4:0]  rf_wr_idx_o,
  output logic [31:0] rf_wr_value_o,
  input  logic        rf_wr_ready_i,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WB, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] result;
  logic        accept;
  logic        rd_nz;
  logic        wd_expire;
  logic        wd_fire;

  assign issue_ready_o = (state == IDLE) & ~flush_i;
  assign accept        = issue_valid_i & issue_ready_o;
  assign rd_nz         = (div_rd_idx_o != 5'd0);

`ifdef RISCV_DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  // Counter restarts on every state change, so WAIT and DRAIN each get a full window.
  assign wd_expire = ((state == WAIT) || (state == DRAIN)) && !div_wb_valid_i &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign wd_fire   = (state == WAIT) && wd_expire && !flush_i;
  assign timeout_o = wd_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
    end else if (state_nxt != state) begin
      wd_cnt <= '0;
    end else if ((state == WAIT) || (state == DRAIN)) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wd_fire   = 1'b0;
  // Watchdog compiled out; the parameter only matters when it is built in.
  assign timeout_o = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = LAUNCH;
      LAUNCH: state_nxt = flush_i ? DRAIN : WAIT;
      WAIT: begin
        if (div_wb_valid_i) begin
          state_nxt = (rd_nz && !flush_i) ? WB : IDLE;
        end else if (flush_i) begin
          state_nxt = DRAIN;
        end else if (wd_fire) begin
          state_nxt = rd_nz ? WB : IDLE;
        end
      end
      WB:     if (rf_wr_ready_i || flush_i) state_nxt = IDLE;
      DRAIN:  if (div_wb_valid_i || wd_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Launch payload: captured on acceptance, held until the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_opcode_o     <= '0;
      div_pc_o         <= '0;
      div_rd_idx_o     <= '0;
      div_ra_idx_o     <= '0;
      div_rb_idx_o     <= '0;
      div_ra_operand_o <= '0;
      div_rb_operand_o <= '0;
    end else if (accept) begin
      div_opcode_o     <= issue_opcode_i;
      div_pc_o         <= issue_pc_i;
      div_rd_idx_o     <= issue_rd_idx_i;
      div_ra_idx_o     <= issue_ra_idx_i;
      div_rb_idx_o     <= issue_rb_idx_i;
      div_ra_operand_o <= issue_ra_operand_i;
      div_rb_operand_o <= issue_rb_operand_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result <= '0;
    end else if (state == WAIT) begin
      if (div_wb_valid_i) begin
        result <= div_wb_value_i;
      end else if (wd_fire) begin
        result <= 32'hFFFF_FFFF;
      end
    end
  end

  assign div_valid_o   = (state == LAUNCH);
  assign busy_o        = (state != IDLE);
  assign rf_wr_valid_o = (state == WB);
  assign rf_wr_idx_o   = rf_wr_valid_o ? div_rd_idx_o : 5'd0;
  assign rf_wr_value_o = rf_wr_valid_o ? result : 32'd0;

  assign hazard_o = ((state == LAUNCH) || (state == WAIT) || (state == WB)) && rd_nz &&
                    ((hz_ra_idx_i == div_rd_idx_o) || (hz_rb_idx_i == div_rd_idx_o));

endmodule

// File: tb/tb_riscv_base_div_ctrl.sv
// Randomized bench for riscv_base_div_ctrl: the bench plays issue stage, divider and RF arbiter,
// and predicts results with an arithmetic RISC-V divide model.
module tb_riscv_base_div_ctrl;
`ifdef RISCV_DIV_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_ready_o;
  logic [31:0] issue_opcode_i, issue_pc_i, issue_ra_operand_i, issue_rb_operand_i;
  logic [4:0]  issue_rd_idx_i, issue_ra_idx_i, issue_rb_idx_i;
  logic        div_valid_o;
  logic [31:0] div_opcode_o, div_pc_o, div_ra_operand_o, div_rb_operand_o;
  logic [4:0]  div_rd_idx_o, div_ra_idx_o, div_rb_idx_o;
  logic        div_wb_valid_i;
  logic [31:0] div_wb_value_i;
  logic        flush_i;
  logic [4:0]  hz_ra_idx_i, hz_rb_idx_i;
  logic        hazard_o, rf_wr_valid_o, rf_wr_ready_i, busy_o, timeout_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_value_o;

  int checks = 0;
  int errors = 0;

  riscv_base_div_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_opcode_i(issue_opcode_i), .issue_pc_i(issue_pc_i),
    .issue_rd_idx_i(issue_rd_idx_i), .issue_ra_idx_i(issue_ra_idx_i),
    .issue_rb_idx_i(issue_rb_idx_i), .issue_ra_operand_i(issue_ra_operand_i),
    .issue_rb_operand_i(issue_rb_operand_i),
    .div_valid_o(div_valid_o), .div_opcode_o(div_opcode_o), .div_pc_o(div_pc_o),
    .div_rd_idx_o(div_rd_idx_o), .div_ra_idx_o(div_ra_idx_o), .div_rb_idx_o(div_rb_idx_o),
    .div_ra_operand_o(div_ra_operand_o), .div_rb_operand_o(div_rb_operand_o),
    .div_wb_valid_i(div_wb_valid_i), .div_wb_value_i(div_wb_value_i),
    .flush_i(flush_i), .hz_ra_idx_i(hz_ra_idx_i), .hz_rb_idx_i(hz_rb_idx_i),
    .hazard_o(hazard_o), .rf_wr_valid_o(rf_wr_valid_o), .rf_wr_idx_o(rf_wr_idx_o),
    .rf_wr_value_o(rf_wr_value_o), .rf_wr_ready_i(rf_wr_ready_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension divide/remainder semantics, including /0 and overflow.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic hz_exp(input logic [4:0] rd, input bit pend);
    return pend && (rd != 0) && ((hz_ra_idx_i == rd) || (hz_rb_idx_i == rd));
  endfunction

  task automatic set_hz(input logic [4:0] rd);
    hz_ra_idx_i = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
    hz_rb_idx_i = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
  endtask

  task automatic garbage_issue();
    issue_valid_i      = 1'($urandom);
    issue_opcode_i     = $urandom;
    issue_pc_i         = $urandom;
    issue_rd_idx_i     = 5'($urandom);
    issue_ra_operand_i = $urandom;
    issue_rb_operand_i = $urandom;
  endtask

  task automatic chk(input string ph, input logic busy, input logic rdy, input logic dv,
                     input logic wv, input logic hz);
    check({ph, "_busy"}, 32'(busy_o), 32'(busy));
    check({ph, "_issue_ready"}, 32'(issue_ready_o), 32'(rdy));
    check({ph, "_div_valid"}, 32'(div_valid_o), 32'(dv));
    check({ph, "_rf_valid"}, 32'(rf_wr_valid_o), 32'(wv));
    check({ph, "_hazard"}, 32'(hazard_o), 32'(hz));
    check({ph, "_timeout"}, 32'(timeout_o), 32'd0);
  endtask

  // flush_at: -1 none, 0 during launch, k during k-th wait cycle; wb_flush squashes the write.
  task automatic do_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input int rdy_wait,
                       input int flush_at, input bit wb_flush);
    logic [31:0] opc, pc, exp_val, stub_val;
    logic [4:0]  ra, rb;
    bit          pend;
    ra      = 5'($urandom);
    rb      = 5'($urandom);
    pc      = $urandom & ~32'h3;
    opc     = {7'b0000001, rb, ra, f3, rd, 7'b0110011};
    exp_val = ref_div(f3, a, b);

    @(negedge clk_i);
    issue_valid_i = 1'b1; issue_opcode_i = opc; issue_pc_i = pc; issue_rd_idx_i = rd;
    issue_ra_idx_i = ra; issue_rb_idx_i = rb; issue_ra_operand_i = a; issue_rb_operand_i = b;
    set_hz(rd);
    #1 chk("accept", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk_i);
    garbage_issue();
    flush_i = (flush_at == 0);
    set_hz(rd);
    #1 chk("launch", 1'b1, 1'b0, 1'b1, 1'b0, hz_exp(rd, 1'b1));
    check("div_opcode", div_opcode_o, opc);
    check("div_pc", div_pc_o, pc);
    check("div_rd", 32'(div_rd_idx_o), 32'(rd));
    check("div_ra_idx", 32'(div_ra_idx_o), 32'(ra));
    check("div_rb_idx", 32'(div_rb_idx_o), 32'(rb));
    check("div_ra_op", div_ra_operand_o, a);
    check("div_rb_op", div_rb_operand_o, b);
    stub_val = ref_div(div_opcode_o[14:12], div_ra_operand_o, div_rb_operand_o);
    pend = (flush_at != 0);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk_i);
      garbage_issue();
      flush_i        = (flush_at == k);
      div_wb_valid_i = (k == lat);
      div_wb_value_i = (k == lat) ? stub_val : $urandom;
      set_hz(rd);
      #1 chk("wait", 1'b1, 1'b0, 1'b0, 1'b0, hz_exp(rd, pend));
      if (flush_at == k) pend = 1'b0;
    end

    if (pend && rd != 0) begin
      for (int j = 0; j <= rdy_wait; j++) begin
        @(negedge clk_i);
        garbage_issue();
        div_wb_valid_i = 1'($urandom);
        div_wb_value_i = $urandom;
        flush_i        = wb_flush && (j == rdy_wait);
        rf_wr_ready_i  = (j == rdy_wait) ? (wb_flush ? 1'($urandom) : 1'b1) : 1'b0;
        set_hz(rd);
        #1 chk("wb", 1'b1, 1'b0, 1'b0, 1'b1, hz_exp(rd, 1'b1));
        check("wb_idx", 32'(rf_wr_idx_o), 32'(rd));
        check("wb_value", rf_wr_value_o, exp_val);
      end
    end

    @(negedge clk_i);
    issue_valid_i = 1'b0; flush_i = 1'b0; div_wb_valid_i = 1'b0; rf_wr_ready_i = 1'b0;
    set_hz(rd);
    #1 chk("done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] a, b;
  int          lat, mode, flush_at, pulses, fire_at;

  initial begin
    rst_i = 1'b1; issue_valid_i = 0; issue_opcode_i = 0; issue_pc_i = 0; issue_rd_idx_i = 0;
    issue_ra_idx_i = 0; issue_rb_idx_i = 0; issue_ra_operand_i = 0; issue_rb_operand_i = 0;
    div_wb_valid_i = 0; div_wb_value_i = 0; flush_i = 0; hz_ra_idx_i = 0; hz_rb_idx_i = 0;
    rf_wr_ready_i = 0;
    repeat (2) @(negedge clk_i);
    #1 chk("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_div_opcode", div_opcode_o, 32'd0);
    check("reset_div_ra_op", div_ra_operand_o, 32'd0);
    check("reset_rf_value", rf_wr_value_o, 32'd0);
    rst_i = 1'b0;

    do_op(3'b100, 5'd5, 32'd100, 32'd7, 33, 0, -1, 1'b0);   // DIV x5 -> 14
    do_op(3'b111, 5'd3, 32'd17, 32'd5, 6, 4, -1, 1'b0);     // REMU x3 -> 2, ready late
    do_op(3'b101, 5'd0, 32'd50, 32'd3, 5, 0, -1, 1'b0);     // DIVU x0, no write
    do_op(3'b100, 5'd9, 32'd80, 32'd3, 12, 0, 5, 1'b0);     // flush in WAIT
    do_op(3'b100, 5'd7, 32'hFFFF_FF9C, 32'd7, 4, 2, -1, 1'b0);
    do_op(3'b110, 5'd4, 32'd9, 32'd2, 1, 0, -1, 1'b0);      // minimum latency
    do_op(3'b101, 5'd8, 32'd9, 32'd2, 3, 0, 0, 1'b0);       // flush in LAUNCH
    do_op(3'b101, 5'd8, 32'd9, 32'd2, 3, 0, 3, 1'b0);       // flush with result
    do_op(3'b100, 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1, -1, 1'b0);
    do_op(3'b110, 5'd6, 32'd123, 32'd0, 2, 0, -1, 1'b0);
    do_op(3'b100, 5'd2, 32'd10, 32'd5, 2, 2, -1, 1'b1);     // flush in WB

    for (int n = 0; n < 24; n++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 28);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      lat      = $urandom_range(1, 12);
      mode     = $urandom_range(0, 7);
      flush_at = (mode == 0) ? $urandom_range(0, lat) : -1;
      do_op(f3, rd, a, b, lat, $urandom_range(0, 4), flush_at, mode == 1);
    end

    // Stray divider pulse while idle.
    @(negedge clk_i); div_wb_valid_i = 1'b1; div_wb_value_i = $urandom;
    #1 chk("stray", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i); div_wb_valid_i = 1'b0;
    #1 chk("stray_after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-operation, then a late pulse.
    @(negedge clk_i);
    issue_valid_i = 1'b1; issue_rd_idx_i = 5'd11; issue_ra_operand_i = 32'd40;
    issue_rb_operand_i = 32'd4; issue_opcode_i = 32'h0200_45B3;
    @(negedge clk_i); issue_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1 check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_rd", 32'(div_rd_idx_o), 32'd0);
    check("rst_mid_op", div_ra_operand_o, 32'd0);
    @(negedge clk_i); rst_i = 1'b0; div_wb_valid_i = 1'b1; div_wb_value_i = 32'd10;
    @(negedge clk_i); div_wb_valid_i = 1'b0;
    #1 chk("rst_late", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef RISCV_DIV_TIMEOUT_EN
    @(negedge clk_i);
    issue_valid_i = 1'b1; issue_rd_idx_i = 5'd9; issue_opcode_i = 32'h0200_44B3;
    #1 check("to_accept", 32'(issue_ready_o), 32'd1);
    pulses = 0; fire_at = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk_i); issue_valid_i = 1'b0;
      #1;
      if (timeout_o) begin pulses++; fire_at = k; end
      if (rf_wr_valid_o) break;
    end
    check("to_pulses", 32'(pulses), 32'd1);
    check("to_window", 32'((fire_at >= int'(TO)) && (fire_at <= int'(TO) + 1)), 32'd1);
    check("to_wb_valid", 32'(rf_wr_valid_o), 32'd1);
    check("to_wb_idx", 32'(rf_wr_idx_o), 32'd9);
    check("to_wb_value", rf_wr_value_o, 32'hFFFF_FFFF);
    @(negedge clk_i); rf_wr_ready_i = 1'b1;
    @(negedge clk_i); rf_wr_ready_i = 1'b0; div_wb_valid_i = 1'b1; div_wb_value_i = 32'd5;
    #1 check("to_late_busy", 32'(busy_o), 32'd0);
    check("to_late_rf", 32'(rf_wr_valid_o), 32'd0);
    @(negedge clk_i); div_wb_valid_i = 1'b0;
    #1 check("to_late_rf2", 32'(rf_wr_valid_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
